// File: rtl/regfile_mp.sv
// Multi-port register file: one synchronous write port, two combinational read ports,
// optional write-to-read bypass, optional hardwired-zero R0 and a per-register busy scoreboard.
module regfile_mp #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 3,
  parameter bit BYPASS  = 1'b1,
  parameter bit ZERO_R0 = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_a_addr,
  input  logic [ADDR_W-1:0] rd_b_addr,
  output logic [DATA_W-1:0] rd_a_data,
  output logic [DATA_W-1:0] rd_b_data,
  output logic              rd_a_busy,
  output logic              rd_b_busy,
  input  logic              busy_set,
  input  logic [ADDR_W-1:0] busy_addr,
  output logic              any_busy
);

  localparam int NREGS = 2**ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [NREGS-1:0]  busy_q;
  logic [NREGS-1:0]  busy_d;
  logic              wr_ok;
  logic              set_ok;

  // With a hardwired R0, writes and busy marks aimed at address 0 are dropped at the source.
  assign wr_ok  = wr_en    && !(ZERO_R0 && (wr_addr == '0));
  assign set_ok = busy_set && !(ZERO_R0 && (busy_addr == '0));

  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NREGS; i++) begin
      if (wr_ok && (wr_addr == ADDR_W'(i)))    busy_d[i] = 1'b0;
      if (set_ok && (busy_addr == ADDR_W'(i))) busy_d[i] = 1'b1;
    end
  end

  function automatic logic [DATA_W-1:0] read_data(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] d;
    d = regs_q[addr];
    if (BYPASS && wr_ok && (wr_addr == addr)) d = wr_data;
    if (reset || (ZERO_R0 && (addr == '0)))   d = '0;
    return d;
  endfunction

  function automatic logic read_busy(input logic [ADDR_W-1:0] addr);
    logic b;
    b = BYPASS ? busy_d[addr] : busy_q[addr];
    if (reset || (ZERO_R0 && (addr == '0))) b = 1'b0;
    return b;
  endfunction

  always_comb begin
    rd_a_data = read_data(rd_a_addr);
    rd_b_data = read_data(rd_b_addr);
    rd_a_busy = read_busy(rd_a_addr);
    rd_b_busy = read_busy(rd_b_addr);
  end

  assign any_busy = |busy_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      busy_q <= '0;
    end else begin
      if (wr_ok) regs_q[wr_addr] <= wr_data;
      busy_q <= busy_d;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: four configurations driven in parallel and compared against
// an array-based reference model of the register file and scoreboard.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic        busy_set;
  logic [3:0]  wr_addr;
  logic [3:0]  busy_addr;
  logic [3:0]  rd_a_addr;
  logic [3:0]  rd_b_addr;
  logic [31:0] wr_data;

  logic [15:0] a16 [3];
  logic [15:0] b16 [3];
  logic [31:0] a32;
  logic [31:0] b32;
  logic [31:0] ad [4];
  logic [31:0] bd [4];
  logic        ab [4];
  logic        bb [4];
  logic        anyb [4];

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [4][16];
  bit          bsy [4][16];

  always #5 clk = ~clk;

  // u0: defaults, u1: no bypass, u2: hardwired R0, u3: 32-bit x 16 registers
  regfile_mp #(.DATA_W(16), .ADDR_W(3), .BYPASS(1'b1), .ZERO_R0(1'b0)) u0 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr[2:0]), .wr_data(wr_data[15:0]),
    .rd_a_addr(rd_a_addr[2:0]), .rd_b_addr(rd_b_addr[2:0]), .rd_a_data(a16[0]), .rd_b_data(b16[0]),
    .rd_a_busy(ab[0]), .rd_b_busy(bb[0]), .busy_set(busy_set), .busy_addr(busy_addr[2:0]), .any_busy(anyb[0]));
  regfile_mp #(.DATA_W(16), .ADDR_W(3), .BYPASS(1'b0), .ZERO_R0(1'b0)) u1 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr[2:0]), .wr_data(wr_data[15:0]),
    .rd_a_addr(rd_a_addr[2:0]), .rd_b_addr(rd_b_addr[2:0]), .rd_a_data(a16[1]), .rd_b_data(b16[1]),
    .rd_a_busy(ab[1]), .rd_b_busy(bb[1]), .busy_set(busy_set), .busy_addr(busy_addr[2:0]), .any_busy(anyb[1]));
  regfile_mp #(.DATA_W(16), .ADDR_W(3), .BYPASS(1'b1), .ZERO_R0(1'b1)) u2 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr[2:0]), .wr_data(wr_data[15:0]),
    .rd_a_addr(rd_a_addr[2:0]), .rd_b_addr(rd_b_addr[2:0]), .rd_a_data(a16[2]), .rd_b_data(b16[2]),
    .rd_a_busy(ab[2]), .rd_b_busy(bb[2]), .busy_set(busy_set), .busy_addr(busy_addr[2:0]), .any_busy(anyb[2]));
  regfile_mp #(.DATA_W(32), .ADDR_W(4), .BYPASS(1'b1), .ZERO_R0(1'b0)) u3 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_a_addr(rd_a_addr), .rd_b_addr(rd_b_addr), .rd_a_data(a32), .rd_b_data(b32),
    .rd_a_busy(ab[3]), .rd_b_busy(bb[3]), .busy_set(busy_set), .busy_addr(busy_addr), .any_busy(anyb[3]));

  assign ad[0] = {16'h0, a16[0]};
  assign bd[0] = {16'h0, b16[0]};
  assign ad[1] = {16'h0, a16[1]};
  assign bd[1] = {16'h0, b16[1]};
  assign ad[2] = {16'h0, a16[2]};
  assign bd[2] = {16'h0, b16[2]};
  assign ad[3] = a32;
  assign bd[3] = b32;

  function automatic int amask(input int k);
    return (k == 3) ? 15 : 7;
  endfunction

  function automatic logic [31:0] dmask(input int k);
    return (k == 3) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
  endfunction

  function automatic bit byp(input int k);
    return k != 1;
  endfunction

  function automatic bit z0(input int k);
    return k == 2;
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 16; i++) begin
        mem[k][i] = 32'h0;
        bsy[k][i] = 1'b0;
      end
  endfunction

  // One clock edge of the register file: write lands and clears busy, then a mark sets it.
  function automatic void model_step();
    for (int k = 0; k < 4; k++) begin
      int wa = int'(wr_addr) & amask(k);
      int ba = int'(busy_addr) & amask(k);
      if (wr_en && !(z0(k) && wa == 0)) begin
        mem[k][wa] = wr_data & dmask(k);
        bsy[k][wa] = 1'b0;
      end
      if (busy_set && !(z0(k) && ba == 0)) bsy[k][ba] = 1'b1;
    end
  endfunction

  function automatic logic [31:0] exp_data(input int k, input logic [3:0] addr);
    int a  = int'(addr) & amask(k);
    int wa = int'(wr_addr) & amask(k);
    if (reset) return 32'h0;
    if (z0(k) && a == 0) return 32'h0;
    if (byp(k) && wr_en && wa == a) return wr_data & dmask(k);
    return mem[k][a];
  endfunction

  function automatic logic exp_busy(input int k, input logic [3:0] addr);
    int a  = int'(addr) & amask(k);
    int wa = int'(wr_addr) & amask(k);
    int ba = int'(busy_addr) & amask(k);
    bit b;
    if (reset) return 1'b0;
    if (z0(k) && a == 0) return 1'b0;
    b = bsy[k][a];
    if (!byp(k)) return b;
    if (wr_en && wa == a) b = 1'b0;
    if (busy_set && ba == a) b = 1'b1;
    return b;
  endfunction

  function automatic logic exp_any(input int k);
    bit r = 1'b0;
    for (int i = 0; i <= amask(k); i++) r = r | bsy[k][i];
    return r;
  endfunction

  task automatic drive(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                       input logic bs, input logic [3:0] ba, input logic [3:0] ra, input logic [3:0] rb);
    @(negedge clk);
    wr_en = we; wr_addr = wa; wr_data = wd;
    busy_set = bs; busy_addr = ba;
    rd_a_addr = ra; rd_b_addr = rb;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_step();
  endtask

  task automatic test_reset();
    drive(1'b1, 4'd3, 32'h1111_2222, 1'b1, 4'd5, 4'd3, 4'd5);
    for (int k = 0; k < 4; k++) begin
      checks += 5;
      if (ad[k] !== 32'h0) begin errors++; $display("FAIL reset_hold u%0d rd_a_data got %h want 0", k, ad[k]); end
      if (bd[k] !== 32'h0) begin errors++; $display("FAIL reset_hold u%0d rd_b_data got %h want 0", k, bd[k]); end
      if (ab[k] !== 1'b0) begin errors++; $display("FAIL reset_hold u%0d rd_a_busy got %b want 0", k, ab[k]); end
      if (bb[k] !== 1'b0) begin errors++; $display("FAIL reset_hold u%0d rd_b_busy got %b want 0", k, bb[k]); end
      if (anyb[k] !== 1'b0) begin errors++; $display("FAIL reset_hold u%0d any_busy got %b want 0", k, anyb[k]); end
    end
    tick();
    @(negedge clk);
    wr_en = 1'b0; busy_set = 1'b0; reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'(i), 4'(15 - i));
      for (int k = 0; k < 4; k++) begin
        checks += 5;
        if (ad[k] !== 32'h0) begin errors++; $display("FAIL reset_read u%0d rd_a_data[%0d] got %h want 0", k, i, ad[k]); end
        if (bd[k] !== 32'h0) begin errors++; $display("FAIL reset_read u%0d rd_b_data[%0d] got %h want 0", k, 15 - i, bd[k]); end
        if (ab[k] !== 1'b0) begin errors++; $display("FAIL reset_read u%0d rd_a_busy got %b want 0", k, ab[k]); end
        if (bb[k] !== 1'b0) begin errors++; $display("FAIL reset_read u%0d rd_b_busy got %b want 0", k, bb[k]); end
        if (anyb[k] !== 1'b0) begin errors++; $display("FAIL reset_read u%0d any_busy got %b want 0", k, anyb[k]); end
      end
    end
  endtask

  task automatic test_write_read();
    drive(1'b1, 4'd3, 32'h0000_BEEF, 1'b0, 4'd0, 4'd0, 4'd0);
    tick();
    drive(1'b1, 4'd5, 32'h0000_1234, 1'b0, 4'd0, 4'd0, 4'd0);
    tick();
    drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd3, 4'd5);
    checks += 2;
    if (ad[0] !== 32'h0000_BEEF) begin errors++; $display("FAIL wr_rd_a u0 got %h want 0000beef", ad[0]); end
    if (bd[0] !== 32'h0000_1234) begin errors++; $display("FAIL wr_rd_b u0 got %h want 00001234", bd[0]); end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'(i), 4'(7 - i));
      for (int k = 0; k < 4; k++) begin
        checks += 2;
        if (ad[k] !== exp_data(k, rd_a_addr)) begin errors++; $display("FAIL wr_sweep u%0d rd_a_data[%0d] got %h want %h", k, i, ad[k], exp_data(k, rd_a_addr)); end
        if (bd[k] !== exp_data(k, rd_b_addr)) begin errors++; $display("FAIL wr_sweep u%0d rd_b_data[%0d] got %h want %h", k, 7 - i, bd[k], exp_data(k, rd_b_addr)); end
      end
    end
  endtask

  task automatic test_bypass();
    drive(1'b1, 4'd2, 32'h0000_A5A5, 1'b0, 4'd0, 4'd2, 4'd3);
    checks += 2;
    if (ad[0] !== 32'h0000_A5A5) begin errors++; $display("FAIL bypass_on u0 got %h want 0000a5a5", ad[0]); end
    if (ad[1] !== 32'h0) begin errors++; $display("FAIL bypass_off u1 got %h want 0", ad[1]); end
    for (int k = 0; k < 4; k++) begin
      checks += 2;
      if (ad[k] !== exp_data(k, rd_a_addr)) begin errors++; $display("FAIL bypass_a u%0d got %h want %h", k, ad[k], exp_data(k, rd_a_addr)); end
      if (bd[k] !== exp_data(k, rd_b_addr)) begin errors++; $display("FAIL bypass_b u%0d got %h want %h", k, bd[k], exp_data(k, rd_b_addr)); end
    end
    tick();
    drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd2, 4'd2);
    checks += 2;
    if (ad[1] !== 32'h0000_A5A5) begin errors++; $display("FAIL bypass_next u1 got %h want 0000a5a5", ad[1]); end
    if (bd[0] !== 32'h0000_A5A5) begin errors++; $display("FAIL bypass_next u0 got %h want 0000a5a5", bd[0]); end
  endtask

  task automatic test_scoreboard();
    drive(1'b0, 4'd0, 32'h0, 1'b1, 4'd6, 4'd6, 4'd6);
    tick();
    drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd6, 4'd5);
    checks += 4;
    if (ab[0] !== 1'b1) begin errors++; $display("FAIL sb_set u0 rd_a_busy got %b want 1", ab[0]); end
    if (anyb[0] !== 1'b1) begin errors++; $display("FAIL sb_set u0 any_busy got %b want 1", anyb[0]); end
    if (ab[1] !== 1'b1) begin errors++; $display("FAIL sb_set u1 rd_a_busy got %b want 1", ab[1]); end
    if (bb[0] !== 1'b0) begin errors++; $display("FAIL sb_set u0 rd_b_busy got %b want 0", bb[0]); end
    drive(1'b1, 4'd6, 32'h0000_0042, 1'b0, 4'd0, 4'd6, 4'd6);
    checks += 3;
    if (ab[0] !== 1'b0) begin errors++; $display("FAIL sb_clr_byp u0 rd_a_busy got %b want 0", ab[0]); end
    if (ab[1] !== 1'b1) begin errors++; $display("FAIL sb_clr_nobyp u1 rd_a_busy got %b want 1", ab[1]); end
    if (anyb[0] !== 1'b1) begin errors++; $display("FAIL sb_clr_pre u0 any_busy got %b want 1", anyb[0]); end
    tick();
    drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd6, 4'd6);
    checks += 3;
    if (anyb[0] !== 1'b0) begin errors++; $display("FAIL sb_clr u0 any_busy got %b want 0", anyb[0]); end
    if (ab[1] !== 1'b0) begin errors++; $display("FAIL sb_clr u1 rd_a_busy got %b want 0", ab[1]); end
    if (ad[0] !== 32'h0000_0042) begin errors++; $display("FAIL sb_clr u0 rd_a_data got %h want 00000042", ad[0]); end
    drive(1'b1, 4'd6, 32'h0000_1357, 1'b1, 4'd6, 4'd6, 4'd6);
    for (int k = 0; k < 4; k++) begin
      checks += 2;
      if (ab[k] !== exp_busy(k, rd_a_addr)) begin errors++; $display("FAIL sb_both_pre u%0d rd_a_busy got %b want %b", k, ab[k], exp_busy(k, rd_a_addr)); end
      if (ad[k] !== exp_data(k, rd_a_addr)) begin errors++; $display("FAIL sb_both_pre u%0d rd_a_data got %h want %h", k, ad[k], exp_data(k, rd_a_addr)); end
    end
    tick();
    drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd6, 4'd6);
    checks += 3;
    if (ab[0] !== 1'b1) begin errors++; $display("FAIL sb_both u0 rd_a_busy got %b want 1", ab[0]); end
    if (anyb[0] !== 1'b1) begin errors++; $display("FAIL sb_both u0 any_busy got %b want 1", anyb[0]); end
    if (ad[0] !== 32'h0000_1357) begin errors++; $display("FAIL sb_both u0 rd_a_data got %h want 00001357", ad[0]); end
    drive(1'b1, 4'd6, 32'h0000_0042, 1'b0, 4'd0, 4'd6, 4'd6);
    tick();
  endtask

  task automatic test_zero_r0();
    drive(1'b1, 4'd0, 32'h0000_FFFF, 1'b1, 4'd0, 4'd0, 4'd0);
    checks += 2;
    if (ad[2] !== 32'h0) begin errors++; $display("FAIL r0_byp u2 rd_a_data got %h want 0", ad[2]); end
    if (ab[2] !== 1'b0) begin errors++; $display("FAIL r0_byp u2 rd_a_busy got %b want 0", ab[2]); end
    tick();
    drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd0, 4'd0);
    checks += 5;
    if (ad[2] !== 32'h0) begin errors++; $display("FAIL r0 u2 rd_a_data got %h want 0", ad[2]); end
    if (bb[2] !== 1'b0) begin errors++; $display("FAIL r0 u2 rd_b_busy got %b want 0", bb[2]); end
    if (anyb[2] !== 1'b0) begin errors++; $display("FAIL r0 u2 any_busy got %b want 0", anyb[2]); end
    if (ad[0] !== 32'h0000_FFFF) begin errors++; $display("FAIL r0_plain u0 rd_a_data got %h want 0000ffff", ad[0]); end
    if (ab[0] !== 1'b1) begin errors++; $display("FAIL r0_plain u0 rd_a_busy got %b want 1", ab[0]); end
    drive(1'b1, 4'd0, 32'h0, 1'b0, 4'd0, 4'd0, 4'd0);
    tick();
  endtask

  task automatic test_async_reset();
    drive(1'b1, 4'd7, 32'h0000_7777, 1'b1, 4'd1, 4'd7, 4'd1);
    tick();
    drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd7, 4'd1);
    checks += 2;
    if (ad[0] !== 32'h0000_7777) begin errors++; $display("FAIL arst_pre u0 rd_a_data got %h want 00007777", ad[0]); end
    if (bb[0] !== 1'b1) begin errors++; $display("FAIL arst_pre u0 rd_b_busy got %b want 1", bb[0]); end
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    for (int k = 0; k < 4; k++) begin
      checks += 3;
      if (ad[k] !== 32'h0) begin errors++; $display("FAIL arst_mid u%0d rd_a_data got %h want 0", k, ad[k]); end
      if (bb[k] !== 1'b0) begin errors++; $display("FAIL arst_mid u%0d rd_b_busy got %b want 0", k, bb[k]); end
      if (anyb[k] !== 1'b0) begin errors++; $display("FAIL arst_mid u%0d any_busy got %b want 0", k, anyb[k]); end
    end
    drive(1'b1, 4'd4, 32'h0000_4444, 1'b1, 4'd4, 4'd4, 4'd4);
    checks += 2;
    if (ad[0] !== 32'h0) begin errors++; $display("FAIL arst_byp u0 rd_a_data got %h want 0", ad[0]); end
    if (ab[0] !== 1'b0) begin errors++; $display("FAIL arst_byp u0 rd_a_busy got %b want 0", ab[0]); end
    tick();
    @(negedge clk);
    wr_en = 1'b0; busy_set = 1'b0; reset = 1'b0;
    tick();
    drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd4, 4'd7);
    for (int k = 0; k < 4; k++) begin
      checks += 4;
      if (ad[k] !== 32'h0) begin errors++; $display("FAIL arst_post u%0d rd_a_data got %h want 0", k, ad[k]); end
      if (bd[k] !== 32'h0) begin errors++; $display("FAIL arst_post u%0d rd_b_data got %h want 0", k, bd[k]); end
      if (ab[k] !== 1'b0) begin errors++; $display("FAIL arst_post u%0d rd_a_busy got %b want 0", k, ab[k]); end
      if (anyb[k] !== 1'b0) begin errors++; $display("FAIL arst_post u%0d any_busy got %b want 0", k, anyb[k]); end
    end
  endtask

  task automatic test_wide();
    drive(1'b1, 4'd15, 32'hDEAD_BEEF, 1'b0, 4'd0, 4'd14, 4'd15);
    tick();
    drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd15, 4'd7);
    checks += 3;
    if (ad[3] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wide u3 rd_a_data got %h want deadbeef", ad[3]); end
    if (bd[3] !== 32'h0) begin errors++; $display("FAIL wide u3 rd_b_data got %h want 0", bd[3]); end
    if (ad[0] !== 32'h0000_BEEF) begin errors++; $display("FAIL wide_alias u0 rd_a_data got %h want 0000beef", ad[0]); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), 4'($urandom), $urandom, 1'($urandom_range(0, 2) == 0),
            4'($urandom), 4'($urandom), 4'($urandom));
      for (int k = 0; k < 4; k++) begin
        checks += 5;
        if (ad[k] !== exp_data(k, rd_a_addr)) begin errors++; $display("FAIL rand u%0d rd_a_data got %h want %h", k, ad[k], exp_data(k, rd_a_addr)); end
        if (bd[k] !== exp_data(k, rd_b_addr)) begin errors++; $display("FAIL rand u%0d rd_b_data got %h want %h", k, bd[k], exp_data(k, rd_b_addr)); end
        if (ab[k] !== exp_busy(k, rd_a_addr)) begin errors++; $display("FAIL rand u%0d rd_a_busy got %b want %b", k, ab[k], exp_busy(k, rd_a_addr)); end
        if (bb[k] !== exp_busy(k, rd_b_addr)) begin errors++; $display("FAIL rand u%0d rd_b_busy got %b want %b", k, bb[k], exp_busy(k, rd_b_addr)); end
        if (anyb[k] !== exp_any(k)) begin errors++; $display("FAIL rand u%0d any_busy got %b want %b", k, anyb[k], exp_any(k)); end
      end
      tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    wr_en = 1'b0; wr_addr = 4'd0; wr_data = 32'h0;
    busy_set = 1'b0; busy_addr = 4'd0;
    rd_a_addr = 4'd0; rd_b_addr = 4'd0;
    model_clear();
    test_reset();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_zero_r0();
    test_async_reset();
    test_wide();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
